cc_bbox_extractor: RTL and testbench
====================================

Name: cc_bbox_extractor

Overview:
- Downstream consumer of the connected-components label stream produced by the detection top level. Inputs per pixel: label, x, y; frame boundaries come from vsync.
- Accumulates per-label bounding box (xmin, xmax, ymin, ymax) and pixel area over one frame.
- At end of frame, streams one record per non-empty label over a valid/ready interface to the overlay/host stage, then clears its table for the next frame.

Parameters:
- WORD_SIZE, 8, label width; matches the global word size.
- MAX_LABELS, 64, table entries. Label 0 is background and is never stored. Labels >= MAX_LABELS are rejected.
- COORD_WIDTH, 11, stored bits of x/y (low bits of the 32-bit inputs).
- AREA_WIDTH, 20, area counter width; the counter saturates.

Ports:
- clk  in  1  system clock
- reset_n  in  1  reset, asynchronous, active-low
- en  in  1  pixel-valid qualifier, same meaning as the upstream pipeline enable
- vsync  in  1  frame sync level; a rising edge marks end of frame
- label  in  WORD_SIZE  connected-components label of the current pixel
- x  in  32  pixel column from the location generator
- y  in  32  pixel row from the location generator
- rd_valid  out  1  a record is presented
- rd_ready  in  1  consumer accepts the record
- rd_label  out  WORD_SIZE  label of the record
- rd_xmin, rd_xmax, rd_ymin, rd_ymax  out  COORD_WIDTH each  bounding box
- rd_area  out  AREA_WIDTH  pixel count
- frame_done  out  1  one-cycle pulse after the last record of a frame has been accepted (or immediately if there are no records)
- overflow  out  1  sticky flag, cleared only by reset; set on a rejected label or on a pixel dropped during DUMP

Behaviour:
- Reset (async, reset_n=0): state=ACCUM; all entry valid bits 0; rd_valid=0; frame_done=0; overflow=0; vsync edge register=0; all rd_* data outputs 0.
- vsync edge detect: a registered copy of vsync. frame_end = vsync & ~vsync_q, sampled on every clock regardless of en.
- States:
  - ACCUM: accumulate pixels; go to DUMP on frame_end.
  - DUMP: scan pointer idx runs 1..MAX_LABELS-1. Invalid entries are skipped at 1 per cycle. Valid entries are presented on rd_*.
  - CLEAR: all valid bits cleared in one cycle; frame_done=1 for that cycle; next state ACCUM.
- Accumulation, in ACCUM with en=1 and label != 0, label < MAX_LABELS; update entry[label] at the clock edge, so a read-modify-write completes in 1 cycle:
  - Entry not valid: xmin=xmax=x[COORD_WIDTH-1:0], ymin=ymax=y[...], area=1, valid=1.
  - Entry valid: xmin=min, xmax=max, ymin=min, ymax=max (unsigned compares); area=area+1, saturating at 2^AREA_WIDTH-1.
  - Back-to-back pixels with the same label each cycle must all count; no hazard bubbles.
- Ignored inputs:
  - label=0 is ignored silently.
  - label >= MAX_LABELS is ignored and sets overflow.
  - en=0: no update.
- Same-cycle pixel and frame_end: the pixel is accumulated into the closing frame, then the state moves to DUMP.
- DUMP handshake:
  - rd_valid rises the cycle after idx reaches a valid entry (registered outputs).
  - rd_* stay stable while rd_valid=1 and rd_ready=0.
  - Transfer occurs on the edge where rd_valid=1 and rd_ready=1; idx then advances.
  - rd_ready is ignored when rd_valid=0. Throughput is at most 1 record per 2 cycles.
- Records are emitted in ascending label order. After idx=MAX_LABELS-1 is done, go to CLEAR.
- Pixels arriving during DUMP/CLEAR (en=1, label != 0) are dropped and set overflow.
- A vsync rising edge during DUMP/CLEAR is ignored; no re-trigger.
- Reset mid-DUMP: immediate return to the reset state; any partial record is discarded (rd_valid=0 asynchronously).
- Empty frame (no valid entries): DUMP scans without asserting rd_valid, then frame_done pulses.

Test Plan:
- Reset then a single pixel: label 3 at (10,20), en=1, then a vsync pulse → exactly one record: label=3, box=(10,10,20,20), area=1, followed by a frame_done pulse.
- Square blob: label 5 over x 4..7, y 2..5 (16 pixels, raster order) plus label 0 pixels → record label=5, xmin=4, xmax=7, ymin=2, ymax=5, area=16.
- Backpressure: labels 2 and 9 each non-empty; rd_ready held 0 for 10 cycles → rd_label=2 and data held stable; then rd_ready=1 → label 2 then label 9 accepted in order; frame_done after the 9 record.
- Bad and late pixels: label 70 (>= MAX_LABELS), and a label 1 pixel sent during DUMP → overflow=1, no record for 70, label 1 absent from the current dump; the next frame starts with an empty table.
- Saturation with AREA_WIDTH=4: 20 pixels of label 1 → area=15.
- Async reset asserted mid-DUMP with rd_valid=1 → rd_valid=0 immediately. After release, a new frame with no pixels → no records, frame_done pulses once.

Source files
------------

// File: rtl/cc_bbox_extractor.sv
// Per-label bounding box and area accumulator over one video frame; at frame end it
// streams one record per non-empty label over valid/ready, then clears its table.
module cc_bbox_extractor #(
   parameter int WORD_SIZE   = 8,
   parameter int MAX_LABELS  = 64,
   parameter int COORD_WIDTH = 11,
   parameter int AREA_WIDTH  = 20
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   en,
   input  logic                   vsync,
   input  logic [WORD_SIZE-1:0]   label,
   input  logic [31:0]            x,
   input  logic [31:0]            y,
   output logic                   rd_valid,
   input  logic                   rd_ready,
   output logic [WORD_SIZE-1:0]   rd_label,
   output logic [COORD_WIDTH-1:0] rd_xmin,
   output logic [COORD_WIDTH-1:0] rd_xmax,
   output logic [COORD_WIDTH-1:0] rd_ymin,
   output logic [COORD_WIDTH-1:0] rd_ymax,
   output logic [AREA_WIDTH-1:0]  rd_area,
   output logic                   frame_done,
   output logic                   overflow,
   output logic [1:0]             dbg_state_o
);
   localparam int IDX_W = $clog2(MAX_LABELS);

   typedef enum logic [1:0] {ACCUM = 2'd0, DUMP = 2'd1, CLEAR = 2'd2} state_t;

   // Handshake: a record transfers on the clock edge where rd_valid and rd_ready are
   // both 1; rd_* hold steady while rd_valid=1, and rd_ready is ignored while rd_valid=0.
   state_t                 state_q;
   logic                   vsync_q;
   logic [IDX_W-1:0]       idx_q;
   logic [MAX_LABELS-1:0]  valid_q;
   logic [COORD_WIDTH-1:0] xmin_q [MAX_LABELS];
   logic [COORD_WIDTH-1:0] xmax_q [MAX_LABELS];
   logic [COORD_WIDTH-1:0] ymin_q [MAX_LABELS];
   logic [COORD_WIDTH-1:0] ymax_q [MAX_LABELS];
   logic [AREA_WIDTH-1:0]  area_q [MAX_LABELS];

   logic                   rd_valid_q, frame_done_q, overflow_q;
   logic [WORD_SIZE-1:0]   rd_label_q;
   logic [COORD_WIDTH-1:0] rd_xmin_q, rd_xmax_q, rd_ymin_q, rd_ymax_q;
   logic [AREA_WIDTH-1:0]  rd_area_q;

   logic                   frame_end, pix, in_range, acc_we, last_idx, dump_step;
   logic [IDX_W-1:0]       lbl_idx;
   logic [COORD_WIDTH-1:0] x_c, y_c;
   logic [COORD_WIDTH-1:0] xmin_d, xmax_d, ymin_d, ymax_d;
   logic [AREA_WIDTH-1:0]  area_d;
   logic                   unused_coord_bits;

   assign frame_end = vsync & ~vsync_q;
   assign pix       = en && (label != '0);
   assign in_range  = 32'(label) < 32'(MAX_LABELS);
   assign acc_we    = (state_q == ACCUM) && pix && in_range;
   assign lbl_idx   = label[IDX_W-1:0];
   assign x_c       = x[COORD_WIDTH-1:0];
   assign y_c       = y[COORD_WIDTH-1:0];
   assign last_idx  = (idx_q == IDX_W'(MAX_LABELS - 1));
   // The scan pointer moves past an entry once it is skipped or its record is taken.
   assign dump_step = (state_q == DUMP) && (rd_valid_q ? rd_ready : !valid_q[idx_q]);
   assign unused_coord_bits = ^{x[31:COORD_WIDTH], y[31:COORD_WIDTH]};

   always_comb begin
      xmin_d = x_c;
      xmax_d = x_c;
      ymin_d = y_c;
      ymax_d = y_c;
      area_d = AREA_WIDTH'(1);
      if (valid_q[lbl_idx]) begin
         xmin_d = (x_c < xmin_q[lbl_idx]) ? x_c : xmin_q[lbl_idx];
         xmax_d = (x_c > xmax_q[lbl_idx]) ? x_c : xmax_q[lbl_idx];
         ymin_d = (y_c < ymin_q[lbl_idx]) ? y_c : ymin_q[lbl_idx];
         ymax_d = (y_c > ymax_q[lbl_idx]) ? y_c : ymax_q[lbl_idx];
         area_d = (&area_q[lbl_idx]) ? area_q[lbl_idx] : area_q[lbl_idx] + AREA_WIDTH'(1);
      end
   end

   // Table payload needs no reset: the valid bits decide whether it is ever read.
   always_ff @(posedge clk) begin
      if (acc_we) begin
         xmin_q[lbl_idx] <= xmin_d;
         xmax_q[lbl_idx] <= xmax_d;
         ymin_q[lbl_idx] <= ymin_d;
         ymax_q[lbl_idx] <= ymax_d;
         area_q[lbl_idx] <= area_d;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= ACCUM;
         vsync_q      <= 1'b0;
         idx_q        <= IDX_W'(1);
         valid_q      <= '0;
         rd_valid_q   <= 1'b0;
         rd_label_q   <= '0;
         rd_xmin_q    <= '0;
         rd_xmax_q    <= '0;
         rd_ymin_q    <= '0;
         rd_ymax_q    <= '0;
         rd_area_q    <= '0;
         frame_done_q <= 1'b0;
         overflow_q   <= 1'b0;
      end else begin
         vsync_q      <= vsync;
         frame_done_q <= 1'b0;
         if (pix && ((state_q != ACCUM) || !in_range)) overflow_q <= 1'b1;
         case (state_q)
            ACCUM: begin
               if (acc_we) valid_q[lbl_idx] <= 1'b1;
               if (frame_end) begin
                  state_q <= DUMP;
                  idx_q   <= IDX_W'(1);
               end
            end
            DUMP: begin
               if (rd_valid_q && rd_ready) begin
                  rd_valid_q <= 1'b0;
               end else if (!rd_valid_q && valid_q[idx_q]) begin
                  rd_valid_q <= 1'b1;
                  rd_label_q <= WORD_SIZE'(idx_q);
                  rd_xmin_q  <= xmin_q[idx_q];
                  rd_xmax_q  <= xmax_q[idx_q];
                  rd_ymin_q  <= ymin_q[idx_q];
                  rd_ymax_q  <= ymax_q[idx_q];
                  rd_area_q  <= area_q[idx_q];
               end
               if (dump_step) begin
                  if (last_idx) begin
                     state_q      <= CLEAR;
                     frame_done_q <= 1'b1;
                  end else begin
                     idx_q <= idx_q + IDX_W'(1);
                  end
               end
            end
            CLEAR: begin
               valid_q <= '0;
               state_q <= ACCUM;
            end
            default: state_q <= ACCUM;
         endcase
      end
   end

   assign rd_valid    = rd_valid_q;
   assign rd_label    = rd_label_q;
   assign rd_xmin     = rd_xmin_q;
   assign rd_xmax     = rd_xmax_q;
   assign rd_ymin     = rd_ymin_q;
   assign rd_ymax     = rd_ymax_q;
   assign rd_area     = rd_area_q;
   assign frame_done  = frame_done_q;
   assign overflow    = overflow_q;
   assign dbg_state_o = state_q;
endmodule

// File: tb/tb_cc_bbox_extractor.sv
// Directed bench for cc_bbox_extractor: a default instance plus a 4-bit-area instance
// sharing the same stimulus, so area saturation can be seen alongside normal counting.
module tb_cc_bbox_extractor;
   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        en = 1'b0;
   logic        vsync = 1'b0;
   logic [7:0]  label = '0;
   logic [31:0] x = '0;
   logic [31:0] y = '0;
   logic        rd_ready = 1'b0;

   logic        rd_valid, frame_done, overflow;
   logic [7:0]  rd_label;
   logic [10:0] rd_xmin, rd_xmax, rd_ymin, rd_ymax;
   logic [19:0] rd_area;
   logic [1:0]  dbg_state;

   logic        s_rd_valid, s_frame_done, s_overflow;
   logic [7:0]  s_rd_label;
   logic [10:0] s_rd_xmin, s_rd_xmax, s_rd_ymin, s_rd_ymax;
   logic [3:0]  s_rd_area;
   logic [1:0]  s_dbg_state;

   int n_cmp  = 0;
   int n_fail = 0;
   logic [71:0] exp_q[$];

   cc_bbox_extractor u_dut (
      .clk(clk), .reset_n(reset_n), .en(en), .vsync(vsync), .label(label), .x(x), .y(y),
      .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_label(rd_label),
      .rd_xmin(rd_xmin), .rd_xmax(rd_xmax), .rd_ymin(rd_ymin), .rd_ymax(rd_ymax),
      .rd_area(rd_area), .frame_done(frame_done), .overflow(overflow), .dbg_state_o(dbg_state)
   );

   cc_bbox_extractor #(.AREA_WIDTH(4)) u_sat (
      .clk(clk), .reset_n(reset_n), .en(en), .vsync(vsync), .label(label), .x(x), .y(y),
      .rd_valid(s_rd_valid), .rd_ready(rd_ready), .rd_label(s_rd_label),
      .rd_xmin(s_rd_xmin), .rd_xmax(s_rd_xmax), .rd_ymin(s_rd_ymin), .rd_ymax(s_rd_ymax),
      .rd_area(s_rd_area), .frame_done(s_frame_done), .overflow(s_overflow), .dbg_state_o(s_dbg_state)
   );

   always #5 clk = ~clk;

   function automatic logic [71:0] rec(input int l, input int xmn, input int xmx,
                                       input int ymn, input int ymx, input int ar);
      return {8'(l), 11'(xmn), 11'(xmx), 11'(ymn), 11'(ymx), 20'(ar)};
   endfunction

   function automatic logic [71:0] got_rec();
      return {rd_label, rd_xmin, rd_xmax, rd_ymin, rd_ymax, rd_area};
   endfunction

   // Driver tasks: entered and left at posedge+1.
   task automatic drive_pix(input int l, input int xx, input int yy);
      en = 1'b1; label = 8'(l); x = 32'(xx); y = 32'(yy);
      @(posedge clk); #1;
      en = 1'b0; label = '0; x = '0; y = '0;
   endtask

   task automatic pulse_vsync();
      vsync = 1'b1;
      @(posedge clk); #1;
      vsync = 1'b0;
   endtask

   task automatic wait_valid(input string name);
      int cyc = 0;
      while (!rd_valid && cyc < 200) begin
         @(negedge clk);
         cyc++;
      end
      n_cmp++;
      if (rd_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL %s_wait_valid: rd_valid=%b after %0d cycles, expected 1", name, rd_valid, cyc);
      end
      @(posedge clk); #1;
   endtask

   // Accept records with rd_ready=1 until frame_done, checking each against exp_q.
   task automatic collect(input string name);
      int cyc = 0;
      int fd = 0;
      int extra = 0;
      logic [71:0] got, exp;
      rd_ready = 1'b1;
      while (fd == 0 && cyc < 300) begin
         @(negedge clk);
         cyc++;
         if (rd_valid) begin
            got = got_rec();
            n_cmp++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL %s_unexpected_record: got %h, expected no record", name, got);
            end else begin
               exp = exp_q.pop_front();
               if (got !== exp) begin
                  n_fail++;
                  $display("FAIL %s_record: got %h, expected %h", name, got, exp);
               end
            end
         end
         if (frame_done) fd = 1;
      end
      n_cmp++;
      if (fd != 1) begin
         n_fail++;
         $display("FAIL %s_frame_done: not seen within %0d cycles, expected a pulse", name, cyc);
      end
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL %s_missing_records: %0d left, expected 0", name, exp_q.size());
         exp_q.delete();
      end
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (frame_done) extra++;
      end
      n_cmp++;
      if (extra != 0) begin
         n_fail++;
         $display("FAIL %s_frame_done_once: %0d extra pulses, expected 0", name, extra);
      end
      rd_ready = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      n_cmp++;
      if ({rd_valid, frame_done, overflow, dbg_state} !== 5'b0) begin
         n_fail++;
         $display("FAIL reset_flags: got v/fd/ov/st=%b%b%b%0d, expected 0000", rd_valid, frame_done, overflow, dbg_state);
      end
      n_cmp++;
      if (got_rec() !== 72'h0) begin
         n_fail++;
         $display("FAIL reset_data: got %h, expected 0", got_rec());
      end
   endtask

   task automatic test_single_pixel();
      drive_pix(3, 10, 20);
      pulse_vsync();
      exp_q.push_back(rec(3, 10, 10, 20, 20, 1));
      collect("single_pixel");
   endtask

   task automatic test_same_cycle();
      en = 1'b1; label = 8'd7; x = 32'd3; y = 32'd4; vsync = 1'b1;
      @(posedge clk); #1;
      en = 1'b0; label = '0; vsync = 1'b0;
      exp_q.push_back(rec(7, 3, 3, 4, 4, 1));
      collect("same_cycle");
   endtask

   task automatic test_square();
      for (int yy = 2; yy <= 5; yy++)
         for (int xx = 0; xx < 10; xx++)
            drive_pix((xx >= 4 && xx <= 7) ? 5 : 0, xx, yy);
      pulse_vsync();
      exp_q.push_back(rec(5, 4, 7, 2, 5, 16));
      collect("square");
   endtask

   task automatic test_back_to_back_backpressure();
      logic [71:0] rec2;
      drive_pix(9, 100, 50);
      drive_pix(2, 30, 40);
      drive_pix(2, 35, 38);
      drive_pix(9, 90, 60);
      pulse_vsync();
      rec2 = rec(2, 30, 35, 38, 40, 2);
      wait_valid("backpressure");
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         vsync = (i == 3);
         n_cmp++;
         if (rd_valid !== 1'b1 || got_rec() !== rec2) begin
            n_fail++;
            $display("FAIL backpressure_hold: cycle %0d valid=%b got %h, expected %h", i, rd_valid, got_rec(), rec2);
         end
      end
      vsync = 1'b0;
      @(posedge clk); #1;
      exp_q.push_back(rec2);
      exp_q.push_back(rec(9, 90, 100, 50, 60, 2));
      collect("backpressure");
   endtask

   task automatic test_bad_and_late();
      n_cmp++;
      if (overflow !== 1'b0) begin
         n_fail++;
         $display("FAIL overflow_clean: got %b, expected 0", overflow);
      end
      drive_pix(4, 1, 1);
      drive_pix(70, 2, 2);
      n_cmp++;
      if (overflow !== 1'b1) begin
         n_fail++;
         $display("FAIL overflow_bad_label: got %b, expected 1", overflow);
      end
      pulse_vsync();
      wait_valid("late");
      drive_pix(1, 5, 5);
      exp_q.push_back(rec(4, 1, 1, 1, 1, 1));
      collect("late_dump");
      pulse_vsync();
      collect("after_late_empty");
   endtask

   task automatic test_saturation();
      for (int i = 0; i < 20; i++) drive_pix(1, i, 1);
      pulse_vsync();
      wait_valid("saturation");
      n_cmp++;
      if (s_rd_valid !== 1'b1 || s_rd_area !== 4'd15 || s_rd_label !== 8'd1 || s_rd_xmax !== 11'd19) begin
         n_fail++;
         $display("FAIL saturation_area: valid=%b label=%0d xmax=%0d area=%0d, expected 1/1/19/15",
                  s_rd_valid, s_rd_label, s_rd_xmax, s_rd_area);
      end
      exp_q.push_back(rec(1, 0, 19, 1, 1, 20));
      collect("saturation_wide");
   endtask

   task automatic test_reset_mid_dump();
      drive_pix(6, 2, 2);
      pulse_vsync();
      wait_valid("reset_mid");
      #2;
      reset_n = 1'b0;
      #1;
      n_cmp++;
      if (rd_valid !== 1'b0 || dbg_state !== 2'd0 || overflow !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_mid_dump: valid=%b state=%0d ov=%b, expected 0/0/0", rd_valid, dbg_state, overflow);
      end
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk); #1;
      pulse_vsync();
      repeat (5) @(posedge clk);
      #1;
      drive_pix(1, 7, 7);
      collect("empty_after_reset");
      n_cmp++;
      if (overflow !== 1'b1) begin
         n_fail++;
         $display("FAIL overflow_late_pixel: got %b, expected 1", overflow);
      end
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      test_reset();
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk); #1;
      test_reset();
      test_single_pixel();
      test_same_cycle();
      test_square();
      test_back_to_back_backpressure();
      test_bad_and_late();
      test_saturation();
      test_reset_mid_dump();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
